// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receiver driven by the shared 16x oversampling
//   tick. Each frame is start + DBITS data bits (LSB first) + stop, and is
//   delivered as one word with a one-cycle done pulse. A framing-error pulse
//   accompanies done when the stop bit is sampled low.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, an even-parity bit follows the data bits. The PARITY
//     state shows as 11 on state_out, and the parity_err port is added. It
//     pulses with rx_done when the parity does not match.
//
// Parameters
//   DBITS       data bits per frame
//   SB_TICK     oversampling ticks spent in the stop bit (16/24/32 = 1/1.5/2)
//
// Ports
//   clk_100MHz  in   system clock
//   reset       in   synchronous active-low reset
//   rx          in   raw asynchronous serial line, idles high
//   sample_tick in   one-cycle strobe at 16x the baud rate
//   data_out    out  last received word, held until the next frame completes
//   rx_done     out  one-cycle pulse per completed frame
//   frame_err   out  one-cycle pulse with rx_done when the stop bit was low
//   parity_err  out  (UART_RX_PARITY_EN only) pulse with rx_done on bad parity
//   state_out   out  FSM debug: 00 IDLE, 01 START, 10 DATA, 11 STOP/PARITY
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s to fall
// START  | counting to mid start bit; a high line there is a glitch
// DATA   | sampling DBITS data bits, one every 16 ticks
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | waiting SB_TICK ticks, then delivering the word

module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic [1:0]       state_out
);

    // The tick counter must hold at least 15 for the data bits and
    // SB_TICK-1 for the stop bit.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t           state, state_nx;
    logic             rx_meta, rx_s;
    logic [SW-1:0]    s, s_nx;
    logic [NW-1:0]    n, n_nx;
    logic [DBITS-1:0] b, b_nx;
    logic [DBITS-1:0] data_nx;
    logic             done_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
    logic             perr, perr_nx;
    logic             perr_out_nx;
`endif

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            b          <= '0;
            data_out   <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            state      <= state_nx;
            s          <= s_nx;
            n          <= n_nx;
            b          <= b_nx;
            data_out   <= data_nx;
            rx_done    <= done_nx;
            frame_err  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
            perr       <= perr_nx;
            parity_err <= perr_out_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        b_nx     = b;
        data_nx  = data_out;
        done_nx  = 1'b0;
        ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nx     = perr;
        perr_out_nx = 1'b0;
`endif
        case (state)
            IDLE: begin
                // The falling edge is taken without waiting for a tick, so
                // a coincident tick is not counted.
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (s == S_MID) begin
                        s_nx = '0;
                        if (!rx_s) begin
                            state_nx = DATA;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (s == S_BIT) begin
                        s_nx = '0;
                        b_nx = {rx_s, b[DBITS-1:1]};
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = PARITY;
`else
                            state_nx = STOP;
`endif
                        end else begin
                            n_nx = n + 1'b1;
                        end
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_tick) begin
                    if (s == S_BIT) begin
                        s_nx     = '0;
                        perr_nx  = ^{b, rx_s};
                        state_nx = STOP;
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (sample_tick) begin
                    if (s == S_STOP) begin
                        s_nx     = '0;
                        data_nx  = b;
                        done_nx  = 1'b1;
                        ferr_nx  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_out_nx = perr;
`endif
                        state_nx = IDLE;
                    end else begin
                        s_nx = s + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_comb begin
        case (state)
            IDLE:    state_out = 2'b00;
            START:   state_out = 2'b01;
            DATA:    state_out = 2'b10;
            default: state_out = 2'b11;
        endcase
    end
`else
    assign state_out = state;
`endif

endmodule
